data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, range 0..7, meaning the number of wait cycles between request acceptance and the response.
REQ-003 Port clk  input  1  system clock; the block SHALL use one clock and SHALL sample on the rising edge.
REQ-004 Port reset  input  1  reset; it SHALL be asynchronous and active-low (0 = in reset).
REQ-005 Port req_valid  input  1  the initiator presents a request.
REQ-006 Port req_ready  output  1  the block can accept a request.
REQ-007 Port mem_read  input  1  the request is a load.
REQ-008 Port mem_write  input  1  the request is a store.
REQ-009 Port funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 Port addr  input  32  byte address.
REQ-011 Port wdata  input  32  store data, LSB-aligned.
REQ-012 Port rsp_valid  output  1  the response is valid.
REQ-013 Port rsp_ready  input  1  the initiator accepts the response.
REQ-014 Port rdata  output  32  load result, already extended.
REQ-015 Port rsp_err  output  1  the request was rejected; no state change occurred.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid=1 and req_ready=1, capturing mem_read, mem_write, funct3, addr and wdata.
REQ-019 On acceptance, the FSM SHALL go to WAIT with its counter loaded to LATENCY-1 when LATENCY>0, and SHALL go directly to RESP when LATENCY=0.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-021 rsp_valid SHALL be high exactly in the cycles spent in RESP, i.e. first asserted LATENCY+1 cycles after the acceptance edge.
REQ-022 The FSM SHALL hold RESP with rdata and rsp_err stable until an edge with rsp_ready=1, then return to IDLE; no back-to-back acceptance SHALL occur on that same edge.
REQ-023 Store commit and load sampling SHALL occur on the edge entering RESP; memory SHALL be a DEPTH_WORDS x 32 array indexed by addr[31:2].
REQ-024 SB SHALL write byte lane addr[1:0] with wdata[7:0]; SH SHALL write lanes {addr[1],0}..+1 with wdata[15:0]; SW SHALL write all four lanes; other lanes SHALL be unchanged.
REQ-025 LB/LH SHALL sign-extend, and LBU/LHU SHALL zero-extend, the selected byte/half to 32 bits; LW SHALL return the full word; rdata SHALL be 0 for stores.
REQ-026 rsp_err SHALL be 1, with no memory write and rdata=0, for any of the following: mem_read==mem_write; funct3 in {011,110,111}; a store with funct3 in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-027 An erroring request SHALL still take the full LATENCY+1 timing.
REQ-028 Request inputs SHALL be ignored outside of the acceptance edge; changes to them after acceptance SHALL not affect the response.

Reset
REQ-029 While reset=0, the outputs SHALL be: state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_err=0, rdata=0, busy=0.
REQ-030 After reset is released, req_ready SHALL be 1 in the first cycle.
REQ-031 Reset asserted in WAIT SHALL discard the pending store without modifying memory; reset asserted in RESP SHALL drop the response.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 With LATENCY=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> each rsp_valid rises 3 cycles after acceptance; the load returns rdata=0xDEADBEEF with rsp_err=0.
REQ-034 SB addr=0x11 wdata=0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-035 LW addr=0x12 and SH addr=0x13 -> rsp_err=1, rdata=0; a subsequent LW 0x10 is unchanged (0xDEAD80EF).
REQ-036 With DEPTH_WORDS=256, LW addr=0x400 -> rsp_err=1; mem_read=mem_write=1 -> rsp_err=1.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stay stable and req_ready=0; when rsp_ready=1, IDLE is reached on the next edge.
REQ-038 SW 0x20 of 0x12345678 with reset pulsed low during WAIT, then LW 0x20 -> the old value is returned; in a LATENCY=0 build, rsp_valid is seen in the cycle after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake.
// Every request, including a rejected one, completes after a fixed LATENCY+1 cycles.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting down the access latency
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, enter_resp, mem_we;
  logic             cur_rd, cur_wr, cur_err;
  logic [2:0]       cur_f3;
  logic [31:0]      cur_addr, cur_wdata;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word, load_val, store_val;
  logic [3:0]       be;

  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY=0 the access happens on the acceptance edge, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_rd    = mem_read;
      cur_wr    = mem_write;
      cur_f3    = funct3;
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    cur_err = (cur_rd == cur_wr)
           || (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111)
           || (cur_wr && cur_f3[2])
           || ((cur_f3[1:0] == 2'b01) && cur_addr[0])
           || ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00))
           || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    idx  = cur_addr[IDX_W+1:2];
    word = mem[idx];

    load_val = 32'd0;
    case (cur_f3)
      3'b000: load_val = {{24{word[8*cur_addr[1:0]+7]}}, word[8*cur_addr[1:0] +: 8]};
      3'b100: load_val = {24'd0, word[8*cur_addr[1:0] +: 8]};
      3'b001: load_val = {{16{word[16*cur_addr[1]+15]}}, word[16*cur_addr[1] +: 16]};
      3'b101: load_val = {16'd0, word[16*cur_addr[1] +: 16]};
      3'b010: load_val = word;
      default: load_val = 32'd0;
    endcase

    case (cur_f3[1:0])
      2'b00: begin
        be        = 4'b0001 << cur_addr[1:0];
        store_val = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be        = cur_addr[1] ? 4'b1100 : 4'b0011;
        store_val = {2{cur_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        store_val = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d    = mem_read;
          wr_d    = mem_write;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (cur_err || cur_wr) ? 32'd0 : load_val;
      err_d   = cur_err;
    end
  end

  assign mem_we = enter_resp && cur_wr && !cur_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= store_val[8*i +: 8];
      end
    end
  end

endmodule
